// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared seven-segment glyph constants and digit-index width
package sseg_pkg;

  localparam int IDX_W = 2;

  // Active-low {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_sseg_mux3_if.sv
// rtl/bcd_sseg_mux3_if.sv - value/display signal bundle for the 3-digit display mux
interface bcd_sseg_mux3_if;

  logic [11:0] bcd_in;
  logic [2:0]  dp_in;
  logic        blank_lz;
  logic [2:0]  an;
  logic [7:0]  sseg;
  logic        tick;

  modport master (
    output bcd_in, dp_in, blank_lz,
    input  an, sseg, tick
  );

  modport slave (
    input  bcd_in, dp_in, blank_lz,
    output an, sseg, tick
  );

endinterface

// File: rtl/bcd_to_sseg.sv
// rtl/bcd_to_sseg.sv - combinational BCD digit to active-low segment decoder
module bcd_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    if (i_blank) begin
      o_seg = SEG_BLANK;
    end else begin
      case (i_bcd)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_sseg_mux3.sv
// rtl/bcd_sseg_mux3.sv - time-multiplexed 3-digit common-anode display driver
module bcd_sseg_mux3
  import sseg_pkg::*;
#(
  parameter int DIV = 50000,
  parameter int CW  = 20
) (
  input  logic            clk,
  input  logic            reset,
  bcd_sseg_mux3_if.slave  disp
);

  localparam logic [CW-1:0]    CNT_LAST = CW'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2);

  logic [CW-1:0]    r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [11:0]      r_snap;
  logic [2:0]       r_an;
  logic [7:0]       r_sseg;

  logic             w_tick;
  logic [IDX_W-1:0] w_idx_next;
  logic [11:0]      w_word;
  logic [3:0]       w_digit;
  logic             w_blank;
  logic             w_dp;
  logic [2:0]       w_an;
  logic [6:0]       w_seg;

  assign w_tick     = (r_cnt == CNT_LAST);
  assign w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;

  // At the frame wrap the new frame's first digit must come from the value being captured.
  assign w_word = (r_idx == IDX_LAST) ? disp.bcd_in : r_snap;

  always_comb begin
    w_digit = w_word[3:0];
    w_blank = 1'b0;
    w_dp    = disp.dp_in[0];
    w_an    = 3'b110;
    case (w_idx_next)
      2'd1: begin
        w_digit = w_word[7:4];
        w_blank = disp.blank_lz && (w_word[11:4] == 8'h00);
        w_dp    = disp.dp_in[1];
        w_an    = 3'b101;
      end
      2'd2: begin
        w_digit = w_word[11:8];
        w_blank = disp.blank_lz && (w_word[11:8] == 4'h0);
        w_dp    = disp.dp_in[2];
        w_an    = 3'b011;
      end
      default: ;
    endcase
  end

  bcd_to_sseg u_dec (
    .i_bcd   (w_digit),
    .i_blank (w_blank),
    .o_seg   (w_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_idx  <= IDX_LAST;
      r_snap <= 12'h000;
      r_an   <= 3'b111;
      r_sseg <= 8'hFF;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) begin
        r_idx  <= w_idx_next;
        r_an   <= w_an;
        r_sseg <= {~w_dp, w_seg};
        if (r_idx == IDX_LAST) begin
          r_snap <= disp.bcd_in;
        end
      end
    end
  end

  assign disp.an   = r_an;
  assign disp.sseg = r_sseg;
  assign disp.tick = w_tick;

endmodule
